mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control FSM for the MIPS datapath. It sequences each instruction through FETCH/DECODE/EXE/MEM/WB and drives every datapath select the shared 2:1 and 4:1 muxes consume: register-destination, ALU-source, write-data and next-PC. It also drives the PC/IR/GRF/DM write enables and keeps a retired-instruction counter. It sits between the IR/ALU outputs and the datapath; the datapath holds no control state of its own.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 6: IR[31:26], held stable by the IR from DECODE onward.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU equality flag, valid combinationally in EXE.
- `ir_we`, `pc_we`, `reg_we`, `mem_we` output 1 each: IR, PC, GRF and DM write enables.
- `regdst_sel` output 2: 0 selects rt, 1 selects rd, 2 selects 31; 3 is unused.
- `alusrc_sel` output 1: 0 selects the GRF rt data, 1 selects the extended immediate.
- `wdsel` output 2: 0 selects ALU, 1 selects DM, 2 selects PC+4.
- `npc_sel` output 2: 0 selects PC+4, 1 selects the branch target, 2 selects the j target, 3 selects rs.
- `alu_op` output 3: 0 is addu, 1 is subu, 2 is or.
- `ext_op` output 2: 0 is zero-extend, 1 is sign-extend, 2 is lui (imm<<16).
- `state` output 3: current state, exposed for debug.
- `instr_done` output 1: one-cycle pulse in an instruction's last cycle.
- `instr_cnt` output CNT_W: count of retired instructions.

## Operation
- Supported instructions: addu/subu (opcode 0, funct 0x21/0x23), jr (opcode 0, funct 0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
- Any other opcode/funct combination is a nop: it retires in DECODE with PC+4.
- State encoding: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5–7 are illegal and go to FETCH on the next edge with all enables low.
- FETCH: ir_we=1; next state DECODE.
- DECODE:
  - j: last cycle; npc_sel=2, pc_we=1.
  - jr: last cycle; npc_sel=3, pc_we=1.
  - nop: last cycle; npc_sel=0, pc_we=1.
  - jal: next state WB.
  - All other supported instructions: next state EXE.
- EXE, per instruction:
  - addu: alu_op=0, alusrc_sel=0, next state WB.
  - subu: alu_op=1, alusrc_sel=0, next state WB.
  - ori: alu_op=2, ext_op=0, alusrc_sel=1, next state WB.
  - lui: alu_op=2, ext_op=2, alusrc_sel=1, next state WB.
  - lw/sw: alu_op=0, ext_op=1, alusrc_sel=1, next state MEM.
  - beq: alu_op=1, alusrc_sel=0, ext_op=1; last cycle; pc_we=1, npc_sel=zero?1:0.
- MEM:
  - sw: mem_we=1, pc_we=1, npc_sel=0; last cycle.
  - lw: next state WB.
- WB: reg_we=1, pc_we=1, npc_sel=2 for jal and 0 otherwise. regdst_sel and wdsel per instruction:
  - R-type: regdst_sel=1, wdsel=0.
  - ori/lui: regdst_sel=0, wdsel=0.
  - lw: regdst_sel=0, wdsel=1.
  - jal: regdst_sel=2, wdsel=2.
- Select holding: EXE selects stay unchanged through MEM and WB, so ALU/DM paths remain stable.
- Last-cycle rule: every last cycle asserts instr_done=1 and returns to FETCH.
- instr_cnt increments by 1 on each edge where instr_done=1, and wraps at 2^CNT_W.
- Outputs are combinational decodes of state, opcode, funct and zero (Mealy only for beq's npc_sel). Any select not listed for a state is 0.

## Timing
- Reset (takes priority over everything):
  - reset=1 at an edge sets state to FETCH and instr_cnt to 0.
  - While reset is high, all enables and instr_done are forced to 0.
  - Asserting reset mid-instruction abandons that instruction: no further writes and no count.
  - After release, the first cycle is FETCH with ir_we=1.
- CPI by class:
  - j, jr, nop: 2.
  - beq, jal: 3.
  - addu, subu, ori, lui, sw: 4.
  - lw: 5.
- Write-enable exclusivity:
  - At most one of reg_we and mem_we is high in any cycle.
  - pc_we is high in exactly one cycle per instruction, and that cycle is the instr_done cycle.
  - ir_we is high only in FETCH, so opcode and funct are constant from DECODE to the last cycle.
- beq samples zero only in EXE. Changes to zero in any other state have no effect.

## Test plan
- Reset then lui: reset high 2 cycles, then opcode=0x0F. State sequence is 0,1,2,4,0. reg_we=1 only in WB with regdst_sel=0, wdsel=0, ext_op=2. instr_cnt=1 after the WB edge.
- lw vs sw: lw walks 0,1,2,3,4 with wdsel=1 in WB. sw walks 0,1,2,3 with mem_we=1 in MEM and reg_we=0 throughout.
- beq taken/not-taken: zero=1 in EXE gives npc_sel=1 with pc_we=1. zero=0 gives npc_sel=0. Both complete in 3 cycles.
- jal and jr: jal WB shows regdst_sel=2, wdsel=2, npc_sel=2, reg_we=1. jr DECODE shows npc_sel=3, pc_we=1, reg_we=0.
- Illegal and undefined inputs: opcode=0x3F retires in DECODE with npc_sel=0 and no reg_we/mem_we. opcode=0, funct=0x00 behaves identically.
- Reset mid-lw, plus counter wrap:
  - Reset asserted in MEM gives state 0 next cycle, reg_we never asserted, instr_cnt=0.
  - With CNT_W=4, 16 consecutive j instructions wrap instr_cnt to 0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath/IR.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             ir_we;
    logic             pc_we;
    logic             reg_we;
    logic             mem_we;
    logic [1:0]       regdst_sel;
    logic             alusrc_sel;
    logic [1:0]       wdsel;
    logic [1:0]       npc_sel;
    logic [2:0]       alu_op;
    logic [1:0]       ext_op;
    logic [2:0]       state;
    logic             instr_done;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, zero,
        output ir_we, pc_we, reg_we, mem_we, regdst_sel, alusrc_sel, wdsel,
               npc_sel, alu_op, ext_op, state, instr_done, instr_cnt
    );

    modport slave (
        output opcode, funct, zero,
        input  ir_we, pc_we, reg_we, mem_we, regdst_sel, alusrc_sel, wdsel,
               npc_sel, alu_op, ext_op, state, instr_done, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXE/MEM/WB sequencing, datapath
// selects, write enables and a retired-instruction counter.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;

    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_nop;
    logic w_ir_we, w_pc_we, w_reg_we, w_mem_we, w_done, w_alu_st;

    always_comb begin
        w_rtype = (bus.opcode == 6'h00);
        w_addu  = w_rtype && (bus.funct == 6'h21);
        w_subu  = w_rtype && (bus.funct == 6'h23);
        w_jr    = w_rtype && (bus.funct == 6'h08);
        w_ori   = (bus.opcode == 6'h0D);
        w_lui   = (bus.opcode == 6'h0F);
        w_lw    = (bus.opcode == 6'h23);
        w_sw    = (bus.opcode == 6'h2B);
        w_beq   = (bus.opcode == 6'h04);
        w_j     = (bus.opcode == 6'h02);
        w_jal   = (bus.opcode == 6'h03);
        w_nop   = !(w_addu || w_subu || w_jr || w_ori || w_lui || w_lw ||
                    w_sw || w_beq || w_j || w_jal);
    end

    always_comb begin
        w_next         = S_FETCH;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_reg_we       = 1'b0;
        w_mem_we       = 1'b0;
        w_done         = 1'b0;
        bus.regdst_sel = 2'd0;
        bus.wdsel      = 2'd0;
        bus.npc_sel    = 2'd0;
        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                if (w_j || w_jr || w_nop) begin
                    w_pc_we     = 1'b1;
                    w_done      = 1'b1;
                    bus.npc_sel = w_j ? 2'd2 : (w_jr ? 2'd3 : 2'd0);
                end else if (w_jal) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_beq) begin
                    // zero only matters here; the branch resolves in this cycle
                    w_pc_we     = 1'b1;
                    w_done      = 1'b1;
                    bus.npc_sel = bus.zero ? 2'd1 : 2'd0;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (w_sw) begin
                    w_mem_we = 1'b1;
                    w_pc_we  = 1'b1;
                    w_done   = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                w_reg_we       = 1'b1;
                w_pc_we        = 1'b1;
                w_done         = 1'b1;
                bus.npc_sel    = w_jal ? 2'd2 : 2'd0;
                bus.regdst_sel = w_rtype ? 2'd1 : (w_jal ? 2'd2 : 2'd0);
                bus.wdsel      = w_lw ? 2'd1 : (w_jal ? 2'd2 : 2'd0);
            end
            default: w_next = S_FETCH;
        endcase
    end

    // ALU/extender selects are decoded from the held IR in EXE and kept through MEM/WB
    always_comb begin
        w_alu_st       = (r_state == S_EXE) || (r_state == S_MEM) || (r_state == S_WB);
        bus.alu_op     = 3'd0;
        bus.ext_op     = 2'd0;
        bus.alusrc_sel = 1'b0;
        if (w_alu_st) begin
            if (w_subu || w_beq)     bus.alu_op = 3'd1;
            else if (w_ori || w_lui) bus.alu_op = 3'd2;
            if (w_lui)                      bus.ext_op = 2'd2;
            else if (w_lw || w_sw || w_beq) bus.ext_op = 2'd1;
            bus.alusrc_sel = w_ori || w_lui || w_lw || w_sw;
        end
    end

    assign bus.ir_we      = w_ir_we  & ~reset;
    assign bus.pc_we      = w_pc_we  & ~reset;
    assign bus.reg_we     = w_reg_we & ~reset;
    assign bus.mem_we     = w_mem_we & ~reset;
    assign bus.instr_done = w_done   & ~reset;
    assign bus.state      = r_state;
    assign bus.instr_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_done) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector bench for mc_ctrl: per-cycle state/output vectors for every
// instruction class, reset behaviour and counter wrap (CNT_W=4).
module tb_mc_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    mc_ctrl_if #(.CNT_W(CNT_W)) bus ();
    mc_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {ir,pc,reg,mem,done, regdst, alusrc, wdsel, npc, alu_op, ext_op}
    function automatic logic [16:0] pk(input logic ir, input logic pc, input logic rg,
                                       input logic mm, input logic dn, input logic [1:0] rd,
                                       input logic as, input logic [1:0] wd, input logic [1:0] np,
                                       input logic [2:0] ao, input logic [1:0] eo);
        return {ir, pc, rg, mm, dn, rd, as, wd, np, ao, eo};
    endfunction

    function automatic logic [16:0] obs();
        return {bus.ir_we, bus.pc_we, bus.reg_we, bus.mem_we, bus.instr_done,
                bus.regdst_sel, bus.alusrc_sel, bus.wdsel, bus.npc_sel, bus.alu_op, bus.ext_op};
    endfunction

    // inputs are changed only right after a negedge; check, then move to the next negedge
    task automatic cyc(input string tag, input logic [2:0] st, input logic [16:0] exp);
        #1;
        chk({tag, ".st"}, 32'(bus.state), 32'(st));
        chk({tag, ".out"}, 32'(obs()), 32'(exp));
        @(negedge clk);
    endtask

    task automatic ld(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct  = fn;
    endtask

    initial begin
        reset = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        @(negedge clk);
        chk("rst.st", 32'(bus.state), 32'd0);
        chk("rst.cnt", 32'(bus.instr_cnt), 32'd0);
        chk("rst.out", 32'(obs()), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // lui
        ld(6'h0F, 6'h00);
        cyc("lui.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("lui.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("lui.E", 2, pk(0,0,0,0,0, 0,1,0,0,2,2));
        cyc("lui.W", 4, pk(0,1,1,0,1, 0,1,0,0,2,2));
        chk("lui.cnt", 32'(bus.instr_cnt), 32'd1);

        // lw
        ld(6'h23, 6'h00);
        cyc("lw.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("lw.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("lw.E", 2, pk(0,0,0,0,0, 0,1,0,0,0,1));
        cyc("lw.M", 3, pk(0,0,0,0,0, 0,1,0,0,0,1));
        cyc("lw.W", 4, pk(0,1,1,0,1, 0,1,1,0,0,1));
        chk("lw.cnt", 32'(bus.instr_cnt), 32'd2);

        // sw
        ld(6'h2B, 6'h00);
        cyc("sw.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("sw.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("sw.E", 2, pk(0,0,0,0,0, 0,1,0,0,0,1));
        cyc("sw.M", 3, pk(0,1,0,1,1, 0,1,0,0,0,1));
        chk("sw.cnt", 32'(bus.instr_cnt), 32'd3);

        // beq taken; zero toggling outside EXE must not matter
        ld(6'h04, 6'h00);
        bus.zero = 1'b1;
        cyc("beqt.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("beqt.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("beqt.E", 2, pk(0,1,0,0,1, 0,0,0,1,1,1));
        chk("beqt.cnt", 32'(bus.instr_cnt), 32'd4);

        // beq not taken
        cyc("beqn.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        bus.zero = 1'b0;
        cyc("beqn.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("beqn.E", 2, pk(0,1,0,0,1, 0,0,0,0,1,1));
        chk("beqn.cnt", 32'(bus.instr_cnt), 32'd5);

        // jal
        ld(6'h03, 6'h00);
        cyc("jal.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("jal.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("jal.W", 4, pk(0,1,1,0,1, 2,0,2,2,0,0));

        // jr
        ld(6'h00, 6'h08);
        cyc("jr.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("jr.D", 1, pk(0,1,0,0,1, 0,0,0,3,0,0));
        chk("jr.cnt", 32'(bus.instr_cnt), 32'd7);

        // addu / subu / ori
        ld(6'h00, 6'h21);
        cyc("addu.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("addu.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("addu.E", 2, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("addu.W", 4, pk(0,1,1,0,1, 1,0,0,0,0,0));
        ld(6'h00, 6'h23);
        cyc("subu.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("subu.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("subu.E", 2, pk(0,0,0,0,0, 0,0,0,0,1,0));
        cyc("subu.W", 4, pk(0,1,1,0,1, 1,0,0,0,1,0));
        ld(6'h0D, 6'h00);
        cyc("ori.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("ori.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("ori.E", 2, pk(0,0,0,0,0, 0,1,0,0,2,0));
        cyc("ori.W", 4, pk(0,1,1,0,1, 0,1,0,0,2,0));

        // j and the two nop forms
        ld(6'h02, 6'h00);
        cyc("j.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("j.D", 1, pk(0,1,0,0,1, 0,0,0,2,0,0));
        ld(6'h3F, 6'h00);
        cyc("nop3f.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("nop3f.D", 1, pk(0,1,0,0,1, 0,0,0,0,0,0));
        ld(6'h00, 6'h00);
        cyc("nopr.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("nopr.D", 1, pk(0,1,0,0,1, 0,0,0,0,0,0));
        chk("nop.cnt", 32'(bus.instr_cnt), 32'd13);

        // reset during lw's MEM cycle abandons it
        ld(6'h23, 6'h00);
        cyc("lwr.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));
        cyc("lwr.D", 1, pk(0,0,0,0,0, 0,0,0,0,0,0));
        cyc("lwr.E", 2, pk(0,0,0,0,0, 0,1,0,0,0,1));
        reset = 1'b1;
        cyc("lwr.M", 3, pk(0,0,0,0,0, 0,1,0,0,0,1));
        reset = 1'b0;
        chk("lwr.cnt", 32'(bus.instr_cnt), 32'd0);
        ld(6'h02, 6'h00);
        cyc("post.F", 0, pk(1,0,0,0,0, 0,0,0,0,0,0));

        // finish the j already fetched, then 15 more: 16 retirements wrap a 4-bit count
        cyc("wrap.D0", 1, pk(0,1,0,0,1, 0,0,0,2,0,0));
        for (int i = 1; i < 16; i++) begin
            if (i == 15) chk("wrap.cnt15", 32'(bus.instr_cnt), 32'd15);
            @(negedge clk);
            @(negedge clk);
        end
        chk("wrap.cnt0", 32'(bus.instr_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish, expected done by 20000");
        $fatal(1);
    end
endmodule
